lcd_char_driver: RTL and testbench
==================================

# lcd_char_driver

Parametrised HD44780-compatible character-LCD driver with an on-chip shadow frame buffer. The host writes characters by linear address at any time. The block runs the power-on init sequence itself, then refreshes only the rows marked dirty over the 8-bit LCD bus. It sits between the lab's status/UI logic and the board LCD pins, and supports 1- or 2-line panels of up to 40 columns with cycle-count timing set per clock frequency.

## Interface
- ROWS, 2, display lines; legal values 1 or 2.
- COLS, 16, characters per line; legal range 1..40.
- AW, 6, host address width; must satisfy 2^AW >= ROWS*COLS.
- INIT_WAIT, 180000, power-on delay in cycles before the first command.
- EN_HIGH, 6, number of cycles o_LCD_EN is held high per transaction.
- CMD_WAIT, 480, post-EN cycles for every command and data write except clear.
- CLR_WAIT, 19680, post-EN cycles after the clear-display command.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  1  host character write strobe, one cycle per character.
- i_wr_addr  in  AW  linear address, row*COLS+col.
- i_wr_data  in  8  ASCII / CGROM code.
- i_clear  in  1  fill the whole buffer with 0x20 and mark every row dirty.
- o_init_done  out  1  high once the init sequence has completed; stays high until reset.
- o_busy  out  1  high while an LCD transaction is in flight or any row is dirty.
- io_LCD_DATA  inout  8  LCD data bus; always driven, because RW is fixed at 0.
- o_LCD_EN  out  1  enable strobe.
- o_LCD_RS  out  1  0 = command, 1 = data.
- o_LCD_RW  out  1  constant 0.

## Operation
- Shadow buffer: ROWS*COLS bytes. Reset value 0x20 everywhere. One dirty bit per row; reset value all 1.
- Host write: when i_wr_en is high and i_wr_addr < ROWS*COLS, store the byte and set dirty[i_wr_addr / COLS]. Out-of-range writes are dropped silently.
- i_clear takes priority over i_wr_en in the same cycle.
- Writes are accepted in every state, including during init and during refresh.
- Transaction engine, applied to every command or data byte:
  - Cycle T0: drive RS and DATA, EN = 0.
  - Next EN_HIGH cycles: EN = 1.
  - Then EN = 0 for the wait count (CMD_WAIT, or CLR_WAIT after 0x01).
  - RS and DATA are held stable through the whole transaction.
- States:
  - S_POWER: count INIT_WAIT cycles, then go to S_INIT.
  - S_INIT: issue the fixed commands in order:
    - 0x38 (8-bit mode; 2-line if ROWS=2, otherwise 0x30),
    - 0x0C, 0x01, 0x06.
    - After the last one, set o_init_done and go to S_SCAN.
  - S_SCAN: pick the lowest-index dirty row.
    - If none is dirty, stay in S_SCAN and issue no transaction.
    - Otherwise clear that row's dirty bit and go to S_ADDR.
  - S_ADDR: issue command 0x80 | base, where base = 0x00 for row 0 and 0x40 for row 1. Then go to S_DATA.
  - S_DATA: issue COLS data writes (RS = 1) of buffer[row*COLS + c] for c = 0..COLS-1, each byte read at its own T0. Then return to S_SCAN.
- A host write landing in a row that is currently being refreshed re-sets that row's dirty bit, so the row is refreshed again.
- If a set-dirty and a clear-dirty hit the same row in the same cycle, set wins.
- Reset mid-transaction: all outputs return to their reset values immediately, and the block restarts from S_POWER with the full INIT_WAIT delay.

## Timing
- Reset values:
  - o_LCD_EN = 0, o_LCD_RS = 0, o_LCD_RW = 0, io_LCD_DATA = 0x00.
  - o_init_done = 0, o_busy = 1 (all rows dirty).
- One transaction lasts 1 + EN_HIGH + wait cycles. Consecutive transactions are back-to-back, with no idle cycle between them.
- First EN rising edge: exactly INIT_WAIT + 1 cycles after reset deassertion.
- o_init_done rises in the cycle after the 0x06 wait ends.
- Full refresh of one row: COLS + 1 transactions, plus one cycle in S_SCAN.
- A host write is visible to a refresh that has not yet sampled that byte: registered in the write cycle, readable the next cycle.
- o_busy falls in the cycle S_SCAN finds no dirty row and the engine is idle.

## Test plan
- Reset release with INIT_WAIT=20, EN_HIGH=2, CMD_WAIT=4, CLR_WAIT=8, ROWS=2, COLS=4 -> EN pulses carry 0x38, 0x0C, 0x01, 0x06 in that order, with 8 cycles after 0x01. Then 0x80 followed by four 0x20, then 0xC0 followed by four 0x20. o_init_done rises after 0x06 and o_busy then falls.
- While idle, write 'A' to addr 5 -> only row 1 refreshes: 0xC0, then data 0x20, 'A', 0x20, 0x20 with RS=1. Row 0 shows no traffic.
- Write addr 8 (out of range for 2x4) -> no LCD traffic; o_busy stays low.
- Write 'Z' to addr 1 while row 0 is refreshing and column 2 is being sent -> row 0 is refreshed a second time and the second pass carries 'Z' at column 1.
- Assert i_clear and i_wr_en together -> buffer all 0x20 and both rows refreshed; the written byte is discarded.
- Pull i_rst_n low in the middle of an EN pulse -> EN drops immediately. After release the block repeats the full INIT_WAIT delay and the init sequence.

Source files
------------

// File: rtl/lcd_char_driver.sv
// HD44780-compatible character-LCD driver with a shadow frame buffer.
// Runs the power-on init itself, then refreshes only rows marked dirty over an 8-bit bus.
module lcd_char_driver #(
    parameter int ROWS      = 2,
    parameter int COLS      = 16,
    parameter int AW        = 6,
    parameter int INIT_WAIT = 180000,
    parameter int EN_HIGH   = 6,
    parameter int CMD_WAIT  = 480,
    parameter int CLR_WAIT  = 19680
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_clear,
    output logic          o_init_done,
    output logic          o_busy,
    inout  wire  [7:0]    io_LCD_DATA,
    output logic          o_LCD_EN,
    output logic          o_LCD_RS,
    output logic          o_LCD_RW
);

    localparam int NCHR  = ROWS * COLS;
    localparam int DEPTH = 1 << AW;
    localparam int M1    = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int M2    = (CMD_WAIT > EN_HIGH) ? CMD_WAIT : EN_HIGH;
    localparam int MAXV  = (M1 > M2) ? M1 : M2;
    localparam int CW    = $clog2(MAXV + 1);

    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] EN_LAST   = CW'(EN_HIGH - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_WAIT - 1);
    localparam logic [1:0]    ROW_MASK  = (ROWS == 2) ? 2'b11 : 2'b01;
    localparam logic [7:0]    FUNC_SET  = (ROWS == 2) ? 8'h38 : 8'h30;

    typedef enum logic [2:0] {
        S_POWER,
        S_INIT,
        S_SCAN,
        S_ADDR,
        S_DATA
    } state_t;

    typedef enum logic [1:0] {
        PH_T0,
        PH_EN,
        PH_WAIT
    } phase_t;

    // Handshake: none on the host side -- a write strobe is accepted every cycle it is high.
    state_t        state_q;
    phase_t        ph_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic          row_q;
    logic [5:0]    col_q;
    logic          clr_q;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          en_q;
    logic          init_done_q;

    // Sized to the full address space so the write address indexes it directly;
    // entries at or beyond ROWS*COLS are never written or read.
    logic [7:0]    buf_q [DEPTH];
    logic [1:0]    dirty_q;
    logic [1:0]    dirty_d;

    logic          wr_ok;
    logic          wr_row;
    logic          scan_hit;
    logic          scan_row;
    logic          tx_last;
    logic [5:0]    rd_col;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_byte;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = FUNC_SET;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    assign wr_ok    = i_wr_en && ({1'b0, i_wr_addr} < (AW + 1)'(NCHR));
    assign wr_row   = ({1'b0, i_wr_addr} >= (AW + 1)'(COLS));
    assign scan_hit = (state_q == S_SCAN) && (|dirty_q);
    assign scan_row = ~dirty_q[0];
    assign tx_last  = (ph_q == PH_WAIT) && (cnt_q == (clr_q ? CLR_LAST : CMD_LAST));
    assign rd_col   = (state_q == S_DATA) ? col_q + 6'd1 : 6'd0;
    assign rd_addr  = (row_q ? AW'(COLS) : {AW{1'b0}}) + AW'(rd_col);
    assign rd_byte  = buf_q[rd_addr];

    // Host set beats scan clear on the same row, so a write during refresh re-queues it.
    always_comb begin
        dirty_d = dirty_q;
        if (scan_hit) begin
            dirty_d[scan_row] = 1'b0;
        end
        if (i_clear) begin
            dirty_d = ROW_MASK;
        end else if (wr_ok) begin
            dirty_d[wr_row] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 8'h20;
            end
            dirty_q <= ROW_MASK;
        end else begin
            if (i_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    buf_q[i] <= 8'h20;
                end
            end else if (wr_ok) begin
                buf_q[i_wr_addr] <= i_wr_data;
            end
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_POWER;
            ph_q        <= PH_T0;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            row_q       <= 1'b0;
            col_q       <= 6'd0;
            clr_q       <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_POWER: begin
                    if (cnt_q == INIT_LAST) begin
                        state_q <= S_INIT;
                        idx_q   <= 2'd0;
                        ph_q    <= PH_T0;
                        cnt_q   <= '0;
                        data_q  <= init_cmd(2'd0);
                        rs_q    <= 1'b0;
                        clr_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (|dirty_q) begin
                        state_q <= S_ADDR;
                        row_q   <= scan_row;
                        ph_q    <= PH_T0;
                        cnt_q   <= '0;
                        data_q  <= scan_row ? 8'hC0 : 8'h80;
                        rs_q    <= 1'b0;
                        clr_q   <= 1'b0;
                    end
                end
                default: begin
                    case (ph_q)
                        PH_T0: begin
                            en_q  <= 1'b1;
                            ph_q  <= PH_EN;
                            cnt_q <= '0;
                        end
                        PH_EN: begin
                            if (cnt_q == EN_LAST) begin
                                en_q  <= 1'b0;
                                ph_q  <= PH_WAIT;
                                cnt_q <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            if (!tx_last) begin
                                cnt_q <= cnt_q + 1'b1;
                            end else begin
                                // Next transaction's T0 starts on this edge: no idle cycle between them.
                                ph_q  <= PH_T0;
                                cnt_q <= '0;
                                clr_q <= 1'b0;
                                case (state_q)
                                    S_INIT: begin
                                        if (idx_q == 2'd3) begin
                                            state_q     <= S_SCAN;
                                            init_done_q <= 1'b1;
                                        end else begin
                                            idx_q  <= idx_q + 2'd1;
                                            data_q <= init_cmd(idx_q + 2'd1);
                                            rs_q   <= 1'b0;
                                            clr_q  <= (init_cmd(idx_q + 2'd1) == 8'h01);
                                        end
                                    end
                                    S_ADDR: begin
                                        state_q <= S_DATA;
                                        col_q   <= 6'd0;
                                        data_q  <= rd_byte;
                                        rs_q    <= 1'b1;
                                    end
                                    default: begin
                                        if (col_q == 6'(COLS - 1)) begin
                                            state_q <= S_SCAN;
                                        end else begin
                                            col_q  <= col_q + 6'd1;
                                            data_q <= rd_byte;
                                        end
                                    end
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign io_LCD_DATA = data_q;
    assign o_LCD_EN    = en_q;
    assign o_LCD_RS    = rs_q;
    assign o_LCD_RW    = 1'b0;
    assign o_init_done = init_done_q;
    assign o_busy      = (state_q != S_SCAN) || (|dirty_q);

endmodule

// File: tb/tb_lcd_char_driver.sv
// Scoreboard bench for lcd_char_driver on a 2x4 panel with short timing counts.
module tb_lcd_char_driver;

    localparam int ROWS      = 2;
    localparam int COLS      = 4;
    localparam int AW        = 6;
    localparam int INIT_WAIT = 20;
    localparam int EN_HIGH   = 2;
    localparam int CMD_WAIT  = 4;
    localparam int CLR_WAIT  = 8;

    // EN-low samples before a rising edge: wait cycles plus T0, plus one S_SCAN cycle between rows.
    localparam int G_CMD = CMD_WAIT + 1;
    localparam int G_CLR = CLR_WAIT + 1;
    localparam int G_ROW = CMD_WAIT + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          clear = 1'b0;
    logic          init_done;
    logic          busy;
    logic          lcd_en;
    logic          lcd_rs;
    logic          lcd_rw;
    wire  [7:0]    lcd_data;

    lcd_char_driver #(
        .ROWS(ROWS), .COLS(COLS), .AW(AW), .INIT_WAIT(INIT_WAIT),
        .EN_HIGH(EN_HIGH), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_clear(clear),
        .o_init_done(init_done),
        .o_busy(busy),
        .io_LCD_DATA(lcd_data),
        .o_LCD_EN(lcd_en),
        .o_LCD_RS(lcd_rs),
        .o_LCD_RW(lcd_rw)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int txn_cnt = 0;
    // Entry: {gap[7:0], rs, data}; gap 0 means the idle time before it is not checked.
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int gap, input logic rs, input logic [7:0] d);
        exp_q.push_back({8'(gap), rs, d});
    endtask

    task automatic push_init();
        push_exp(0, 1'b0, 8'h38);
        push_exp(G_CMD, 1'b0, 8'h0C);
        push_exp(G_CMD, 1'b0, 8'h01);
        push_exp(G_CLR, 1'b0, 8'h06);
    endtask

    task automatic push_row(input int first_gap, input logic [7:0] cmd,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        push_exp(first_gap, 1'b0, cmd);
        push_exp(G_CMD, 1'b1, b0);
        push_exp(G_CMD, 1'b1, b1);
        push_exp(G_CMD, 1'b1, b2);
        push_exp(G_CMD, 1'b1, b3);
    endtask

    // Monitor: pops one expected entry on every EN rising edge.
    logic        prev_en = 1'b0;
    int          low_cnt = 0;
    int          hi_cnt = 0;
    logic [8:0]  cur = '0;
    logic [16:0] mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
            low_cnt = 0;
            hi_cnt  = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                txn_cnt++;
                check("rw_low", lcd_rw, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_txn: got rs=%0b data=0x%0h, expected none", lcd_rs, lcd_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("txn_byte", {lcd_rs, lcd_data}, mon_e[8:0]);
                    if (mon_e[16:9] != 8'd0) check("txn_gap", low_cnt, mon_e[16:9]);
                end
                cur     = {lcd_rs, lcd_data};
                hi_cnt  = 1;
                low_cnt = 0;
            end else if (lcd_en) begin
                check("hold_stable", {lcd_rs, lcd_data}, cur);
                hi_cnt++;
            end else begin
                if (prev_en) check("en_width", hi_cnt, EN_HIGH);
                low_cnt++;
            end
            prev_en = lcd_en;
        end
    end

    // Called at an off-edge time; the write is registered on the next rising edge.
    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d, input logic clr);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        clear   = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle"}, busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_en"}, lcd_en, 0);
        check({name, "_rs"}, lcd_rs, 0);
        check({name, "_rw"}, lcd_rw, 0);
        check({name, "_data"}, lcd_data, 8'h00);
        check({name, "_init_done"}, init_done, 0);
        check({name, "_busy"}, busy, 1);
    endtask

    task automatic release_and_boot(input string name);
        int n;
        int base;
        @(negedge clk);
        rst_n = 1'b1;
        base = txn_cnt;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!lcd_en && n < 200);
        check({name, "_first_en_latency"}, n, INIT_WAIT + 1);
        check({name, "_busy_in_init"}, busy, 1);
        n = 0;
        while (!init_done && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_init_done"}, init_done, 1);
        check({name, "_txns_at_init_done"}, txn_cnt - base, 4);
        wait_idle(name, 500);
    endtask

    initial begin
        int n;
        int base;
        int busy_hi;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        push_init();
        push_row(G_ROW, 8'h80, 8'h20, 8'h20, 8'h20, 8'h20);
        push_row(G_ROW, 8'hC0, 8'h20, 8'h20, 8'h20, 8'h20);
        release_and_boot("boot");

        // Single write in row 1 refreshes only row 1.
        push_row(0, 8'hC0, 8'h20, 8'h41, 8'h20, 8'h20);
        host_write(6'd5, 8'h41, 1'b0);
        wait_idle("row1_only", 500);

        // Address 8 is past the 2x4 buffer: dropped, no traffic.
        base = txn_cnt;
        host_write(6'd8, 8'h55, 1'b0);
        busy_hi = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (busy) busy_hi++;
        end
        check("oor_busy_cycles", busy_hi, 0);
        check("oor_txns", txn_cnt - base, 0);

        // Write into row 0 while its column 2 is on the bus: row 0 goes out twice.
        push_row(0, 8'h80, 8'h20, 8'h20, 8'h20, 8'h42);
        base = txn_cnt;
        host_write(6'd3, 8'h42, 1'b0);
        n = 0;
        while (txn_cnt < base + 4 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("col2_reached", txn_cnt - base, 4);
        push_row(G_ROW, 8'h80, 8'h20, 8'h5A, 8'h20, 8'h42);
        host_write(6'd1, 8'h5A, 1'b0);
        wait_idle("rewrite", 500);

        // Clear wins over a same-cycle write.
        push_row(0, 8'h80, 8'h20, 8'h20, 8'h20, 8'h20);
        push_row(G_ROW, 8'hC0, 8'h20, 8'h20, 8'h20, 8'h20);
        host_write(6'd2, 8'h51, 1'b1);
        wait_idle("clear", 500);

        // Reset in the middle of the 0x80 EN pulse.
        push_exp(0, 1'b0, 8'h80);
        host_write(6'd0, 8'h52, 1'b0);
        n = 0;
        while (!lcd_en && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pre_reset_en", lcd_en, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        check("midreset_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        push_init();
        push_row(G_ROW, 8'h80, 8'h20, 8'h20, 8'h20, 8'h20);
        push_row(G_ROW, 8'hC0, 8'h20, 8'h20, 8'h20, 8'h20);
        release_and_boot("reboot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
